// File: rtl/gpio_npu_bridge_if.sv
// gpio_npu_bridge_if: GPIO command/NPU result side and packed frame side.
// master drives board and NPU inputs; slave is the bridge.
interface gpio_npu_bridge_if #(
  parameter int DATA_W     = 16,
  parameter int CH_NUM     = 3,
  parameter int FIFO_DEPTH = 16
);
  logic [3:0]                         gpio_io_i;
  logic [DATA_W-1:0]                  npu_out_data;
  logic                               npu_out_data_vld;
  logic                               cal_start;
  logic                               mode;
  logic                               busy;
  logic [CH_NUM*DATA_W-1:0]           gpio_io_o;
  logic                               out_vld;
  logic [$clog2(CH_NUM+1)-1:0]        lane_cnt;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;
  logic                               overflow;

  modport master (
    output gpio_io_i, npu_out_data, npu_out_data_vld,
    input  cal_start, mode, busy, gpio_io_o,
    input  out_vld, lane_cnt, fifo_count, overflow
  );

  modport slave (
    input  gpio_io_i, npu_out_data, npu_out_data_vld,
    output cal_start, mode, busy, gpio_io_o,
    output out_vld, lane_cnt, fifo_count, overflow
  );
endinterface

// File: rtl/gpio_npu_bridge.sv
// gpio_npu_bridge: GPIO command decode, NPU result FIFO and frame packer.
// Define GPIO_SYNC_EN to add a SYNC_STAGES-deep input synchroniser.
module gpio_npu_bridge #(
  parameter int DATA_W      = 16,
  parameter int CH_NUM      = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  gpio_npu_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int LW = $clog2(CH_NUM+1);

  typedef enum logic {C_IDLE, C_RUN} ctl_e;
  typedef enum logic {RD_IDLE, RD_POP} rd_e;

  logic [3:0] stage;
  logic [3:0] in_q;
  logic [2:0] prev_q;
  logic       start_e;
  logic       read_e;
  logic       clear_e;
  logic       mode_s;

`ifdef GPIO_SYNC_EN
  logic [SYNC_STAGES-1:0][3:0] sync_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.gpio_io_i};
    end
  end

  assign stage = sync_q[SYNC_STAGES-1];
`else
  assign stage = bus.gpio_io_i;
`endif

  // prev_q keeps only the edge-detected bits: {clear, read, start}
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= stage;
      prev_q <= {in_q[3], in_q[2], in_q[0]};
    end
  end

  assign start_e = in_q[0] & ~prev_q[0];
  assign read_e  = in_q[2] & ~prev_q[1];
  assign clear_e = in_q[3] & ~prev_q[2];
  assign mode_s  = in_q[1];

  ctl_e ctl_q, ctl_d;
  logic cal_q, cal_d;
  logic mode_q, mode_d;
  logic flush;

  always_comb begin
    ctl_d  = ctl_q;
    cal_d  = 1'b0;
    mode_d = mode_q;
    flush  = clear_e;
    unique case (ctl_q)
      C_IDLE: begin
        if (start_e && !clear_e) begin
          ctl_d  = C_RUN;
          cal_d  = 1'b1;
          mode_d = mode_s;
          flush  = 1'b1;
        end
      end
      C_RUN: begin
        if (clear_e) ctl_d = C_IDLE;
      end
      default: ctl_d = C_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ctl_q  <= C_IDLE;
      cal_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      cal_q  <= cal_d;
      mode_q <= mode_d;
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              room;
  logic              push;
  logic              drop;
  logic              pop;

  assign room = cnt_q < CW'(FIFO_DEPTH);
  assign push = (ctl_q == C_RUN) && bus.npu_out_data_vld
              && !flush && room;
  assign drop = (ctl_q == C_RUN) && bus.npu_out_data_vld
              && !flush && !room;

  always_ff @(posedge sys_clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wptr_q] <= bus.npu_out_data;
  end

  rd_e                          rds_q, rds_d;
  logic [CH_NUM-1:0][DATA_W-1:0] lanes_q, lanes_d;
  logic [LW-1:0]                n_q, n_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic                         vld_q, vld_d;

  always_comb begin
    rds_d   = rds_q;
    lanes_d = lanes_q;
    n_d     = n_q;
    lane_d  = lane_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    if (flush) begin
      rds_d   = RD_IDLE;
      lanes_d = '0;
      lane_d  = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (rds_q)
        RD_IDLE: begin
          if (read_e) begin
            rds_d   = RD_POP;
            n_d     = (cnt_q >= CW'(CH_NUM)) ? LW'(CH_NUM)
                                             : LW'(cnt_q);
            lanes_d = '0;
            lane_d  = '0;
            vld_d   = 1'b0;
          end
        end
        RD_POP: begin
          if (lane_q == n_q) begin
            rds_d = RD_IDLE;
            vld_d = 1'b1;
          end else begin
            pop = 1'b1;
            for (int i = 0; i < CH_NUM; i++) begin
              if (lane_q == LW'(i)) lanes_d[i] = mem[rptr_q];
            end
            lane_d = lane_q + LW'(1);
            if (lane_d == n_q) begin
              rds_d = RD_IDLE;
              vld_d = 1'b1;
            end
          end
        end
        default: rds_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rds_q   <= RD_IDLE;
      lanes_q <= '0;
      n_q     <= '0;
      lane_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      rds_q   <= rds_d;
      lanes_q <= lanes_d;
      n_q     <= n_d;
      lane_q  <= lane_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.cal_start  = cal_q;
  assign bus.mode       = mode_q;
  assign bus.busy       = (ctl_q == C_RUN);
  assign bus.gpio_io_o  = lanes_q;
  assign bus.out_vld    = vld_q;
  assign bus.lane_cnt   = lane_q;
  assign bus.fifo_count = cnt_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_gpio_npu_bridge.sv
// tb_gpio_npu_bridge: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_gpio_npu_bridge;
  localparam int DW    = 16;
  localparam int CH    = 3;
  localparam int DEPTH = 16;
  localparam int SS    = 2;
`ifdef GPIO_SYNC_EN
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_npu_bridge_if #(
    .DATA_W(DW), .CH_NUM(CH), .FIFO_DEPTH(DEPTH)
  ) bus ();

  gpio_npu_bridge #(
    .DATA_W(DW), .CH_NUM(CH),
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)
  ) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int nvec = 0;
  int nbad = 0;
  int cal_cnt = 0;

  logic [3:0]    hist [8];
  logic [DW-1:0] q [$];
  logic [DW-1:0] ml [CH];
  logic          m_run, m_cal, m_mode, m_ovf, m_outv, m_pop;
  int            m_need, m_got;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: edges seen LAT cycles after sampling, FIFO as a queue.
  task automatic model_step();
    logic st, rd, cl, ok, fl;
    int   sz;
    for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) hist[j] = '0;
      q.delete();
      for (int i = 0; i < CH; i++) ml[i] = '0;
      m_run = 0; m_cal = 0; m_mode = 0; m_ovf = 0;
      m_outv = 0; m_pop = 0; m_need = 0; m_got = 0;
      return;
    end
    hist[0] = bus.gpio_io_i;
    st = hist[LAT][0] & ~hist[LAT+1][0];
    rd = hist[LAT][2] & ~hist[LAT+1][2];
    cl = hist[LAT][3] & ~hist[LAT+1][3];
    ok = !m_run && st && !cl;
    fl = cl || ok;
    sz = q.size();
    m_cal = ok;
    if (ok) m_mode = hist[LAT][1];
    if (fl) begin
      for (int i = 0; i < CH; i++) ml[i] = '0;
      m_pop = 0; m_got = 0; m_outv = 0;
      q.delete();
      m_ovf = 0;
    end else begin
      if (m_pop) begin
        if (m_got < m_need) begin
          ml[m_got] = q.pop_front();
          m_got++;
        end
        if (m_got == m_need) begin
          m_pop = 0;
          m_outv = 1;
        end
      end else if (rd) begin
        m_need = (sz < CH) ? sz : CH;
        m_got = 0;
        for (int i = 0; i < CH; i++) ml[i] = '0;
        m_outv = 0;
        m_pop = 1;
      end
      if (m_run && bus.npu_out_data_vld) begin
        if (sz < DEPTH) q.push_back(bus.npu_out_data);
        else m_ovf = 1;
      end
    end
    m_run = cl ? 1'b0 : (ok ? 1'b1 : m_run);
  endtask

  task automatic compare();
    logic [CH*DW-1:0] frame;
    frame = '0;
    for (int i = 0; i < CH; i++) frame[i*DW +: DW] = ml[i];
    chk("cal_start", bus.cal_start, m_cal);
    chk("busy", bus.busy, m_run);
    chk("mode", bus.mode, m_mode);
    chk("gpio_io_o", bus.gpio_io_o, frame);
    chk("out_vld", bus.out_vld, m_outv);
    chk("lane_cnt", bus.lane_cnt, m_got);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (bus.cal_start) cal_cnt++;
    compare();
  endtask

  task automatic pulse(input logic [3:0] b);
    bus.gpio_io_i = b;
    cycle();
    bus.gpio_io_i = 4'h0;
    cycle();
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.npu_out_data_vld = 1'b1;
      bus.npu_out_data = base + DW'(i);
      cycle();
    end
    bus.npu_out_data_vld = 1'b0;
  endtask

  task automatic rd_frame(input int exp_lat);
    int lat;
    lat = 0;
    bus.gpio_io_i = 4'h4;
    cycle();
    bus.gpio_io_i = 4'h0;
    repeat (LAT) cycle();
    for (int n = 1; n <= 10; n++) begin
      cycle();
      if (bus.out_vld) begin
        lat = n;
        break;
      end
    end
    chk("rd_latency", lat, exp_lat);
  endtask

  initial begin
    bus.gpio_io_i = 4'h0;
    bus.npu_out_data = '0;
    bus.npu_out_data_vld = 1'b0;
    rst_n = 1'b0;
    repeat (3) cycle();
    chk("rst_busy", bus.busy, 0);
    chk("rst_fifo", bus.fifo_count, 0);
    chk("rst_frame", bus.gpio_io_o, 0);
    chk("rst_outv", bus.out_vld, 0);
    rst_n = 1'b1;

    cal_cnt = 0;
    pulse(4'b0011);
    repeat (LAT + 1) cycle();
    chk("start_pulses", cal_cnt, 1);
    chk("start_busy", bus.busy, 1);
    chk("start_mode", bus.mode, 1);
    cal_cnt = 0;
    pulse(4'b0001);
    repeat (LAT + 1) cycle();
    chk("run_start_ignored", cal_cnt, 0);

    for (int i = 1; i <= 4; i++) push_words(1, DW'(i * 'h11));
    chk("push4_count", bus.fifo_count, 4);
    rd_frame(3);
    chk("frame3", bus.gpio_io_o, 48'h003300220011);
    chk("frame3_lanes", bus.lane_cnt, 3);
    chk("frame3_left", bus.fifo_count, 1);
    rd_frame(1);
    chk("frame1", bus.gpio_io_o, 48'h000000000044);
    chk("frame1_lanes", bus.lane_cnt, 1);
    rd_frame(1);
    chk("frame0", bus.gpio_io_o, 48'h0);
    chk("frame0_lanes", bus.lane_cnt, 0);

    push_words(17, 16'h0100);
    chk("ovf_count", bus.fifo_count, 16);
    chk("ovf_flag", bus.overflow, 1);
    rd_frame(3);
    chk("ovf_frame", bus.gpio_io_o, 48'h010201010100);
    pulse(4'b1000);
    repeat (LAT) cycle();
    chk("clr_count", bus.fifo_count, 0);
    chk("clr_ovf", bus.overflow, 0);
    chk("clr_frame", bus.gpio_io_o, 0);
    chk("clr_busy", bus.busy, 0);

    pulse(4'b0001);
    repeat (LAT) cycle();
    chk("mode_relatch", bus.mode, 0);
    push_words(5, 16'h0200);
    bus.npu_out_data_vld = 1'b1;
    bus.npu_out_data = 16'h5a5a;
    rd_frame(3);
    bus.npu_out_data_vld = 1'b0;
    chk("overlap_frame", bus.gpio_io_o, 48'h020202010200);

    bus.gpio_io_i = 4'h4;
    cycle();
    bus.gpio_io_i = 4'h0;
    repeat (LAT + 1) cycle();
    bus.gpio_io_i = 4'h8;
    cycle();
    bus.gpio_io_i = 4'h0;
    repeat (LAT) cycle();
    chk("abort_outv", bus.out_vld, 0);
    chk("abort_lanes", bus.lane_cnt, 0);
    repeat (4) cycle();

    cal_cnt = 0;
    pulse(4'b1001);
    repeat (LAT + 1) cycle();
    chk("start_clr_pulses", cal_cnt, 0);
    chk("start_clr_busy", bus.busy, 0);

    for (int i = 0; i < 3000; i++) begin
      bus.gpio_io_i = {($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 29) == 0)};
      bus.npu_out_data_vld = ($urandom_range(0, 2) != 0);
      bus.npu_out_data = DW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end
endmodule
